tow_ctrl: RTL and testbench
===========================

# tow_ctrl

Tug-of-war round controller: the consumer side of the push-button latch handshake. It sequences each round through a random dark interval, a lit play window and a clear/hold phase. It samples the latch's `push`/`tie`/`right` result, moves the rope position one step per round, and drives `clear` back to the latch. It latches a winner when the rope reaches either end.

## Interface
- `LEDS`, 9: rope positions, odd, ≥3; centre = LEDS/2
- `DARK_MIN`, 16: minimum dark interval, cycles
- `DARK_SHIFT`, 0: left shift applied to the LFSR value when loading the dark interval
- `PLAY_CYCLES`, 32: play-window length before timeout
- `HOLD_CYCLES`, 4: cycles `clear` is held after each round (button-release flush)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-low reset
- `push`  in  1  latch: a player has pressed
- `tie`  in  1  latch: both players latched
- `right`  in  1  latch: right player first, unique
- `clear`  out  1  to latch: clears both latch bits while high
- `leds`  out  LEDS  rope display; one-hot at position, all-zero while dark
- `win_l`  out  1  left player has won (sticky)
- `win_r`  out  1  right player has won (sticky)

## Operation
- States: HOLD, DARK, PLAY, WIN.
- `pos` is an integer from 0 to LEDS-1. Index 0 is the left end.
- Reset (`rst`=0 at an edge):
  - state=HOLD, cnt=HOLD_CYCLES-1, pos=LEDS/2, LFSR=8'h01.
  - Outputs: clear=1, leds=one-hot(LEDS/2), win_l=win_r=0.
- HOLD: clear=1, leds=one-hot(pos). When cnt=0, go to DARK and load cnt=DARK_MIN+(lfsr<<DARK_SHIFT)-1. Otherwise decrement cnt.
- DARK: clear=0, leds=0. Latch is armed, so a press here is a false start.
  - push=1, tie=1: no move.
  - push=1, right=1: pos-1 (right jumped early).
  - push=1, otherwise: pos+1 (left jumped early).
  - After any push in DARK, go to HOLD with cnt=HOLD_CYCLES-1.
  - If cnt=0 with no push, go to PLAY with cnt=PLAY_CYCLES-1.
- PLAY: clear=0, leds=one-hot(pos).
  - push=1, tie=1: no move.
  - push=1, right=1: pos+1.
  - push=1, otherwise: pos-1.
  - After any push in PLAY, go to HOLD.
  - If cnt=0 with no push, timeout: go to HOLD, no move.
- Win check: if the new pos is 0 or LEDS-1, go to WIN instead of HOLD. Set win_l (pos=0) or win_r (pos=LEDS-1).
- WIN: clear=1, leds=one-hot(pos), win flag held. Only reset leaves WIN.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Steps every cycle in every state, including WIN. Never reaches 0.
- Arithmetic:
  - cnt is CNT_W bits.
  - pos moves by exactly ±1 per round; tie never moves it.
  - pos cannot leave 0…LEDS-1, because WIN is entered at the ends.

## Timing
- All outputs are registered. State/pos/clear changes take effect the edge after `push` is sampled.
- The latch is combinational, so `push` drops in the same cycle `clear` rises.
- Simultaneous events:
  - DARK, cnt=0 and push=1 in the same cycle: false start wins; PLAY is not entered.
  - PLAY, cnt=0 and push=1 in the same cycle: the press wins; no timeout.
- Reset mid-round: takes effect at the next edge from any state. pos returns to centre, win flags clear, round restarts in HOLD.
- Durations:
  - Dark interval: DARK_MIN+(lfsr<<DARK_SHIFT) cycles, where lfsr is the value at the HOLD→DARK edge.
  - Play window: PLAY_CYCLES cycles.
  - HOLD: HOLD_CYCLES cycles.
- `push` is ignored in HOLD and WIN.

## Structure
- Package `tow_pkg`:
  - state enum {HOLD, DARK, PLAY, WIN}
  - `CNT_W`=24
  - `LFSR_SEED`=8'h01
  - `LFSR_TAPS`=8'hB8
- Sub-module `lfsr8`: clk, rst, 8-bit q. Steps every cycle; loads the seed on reset.
- `tow_ctrl` holds the FSM, down-counter, pos register, and the leds decode (register one-hot from pos).

## Test plan
All scenarios use defaults (LEDS=9, DARK_MIN=16, DARK_SHIFT=0, PLAY_CYCLES=32, HOLD_CYCLES=4).
1. Reset, then idle with push=0. Required: clear=1 and leds=9'b000010000 for exactly 4 cycles. Then clear=0 and leds=0 for 16–271 cycles. Then leds=9'b000010000 lit for exactly 32 cycles, then back to HOLD with pos=4 unchanged.
2. In PLAY, assert push=1, right=1. Required: next edge pos=5, leds=9'b000100000, clear=1 for 4 cycles. Repeat with right=0 from pos=4: pos=3.
3. In DARK, assert push=1, right=1. Required: pos=3, state HOLD, PLAY skipped. With push=tie=1 in DARK or PLAY: pos unchanged.
4. Drive four consecutive right wins from pos=4. Required: on the 4th, pos=8, win_r=1, clear stays 1. Further push pulses and PLAY timeouts have no effect until rst=0.
5. Assert push in the same cycle as DARK cnt=0: counted as a false start. In the same cycle as PLAY cnt=0: counted as a hit.
6. Assert rst=0 for one cycle during PLAY at pos=6 with win flags clear. Required: next edge pos=4, clear=1, win_l=win_r=0, state HOLD.

Source files
------------

// File: rtl/tow_pkg.sv
// Shared types and constants for the tug-of-war round controller.
package tow_pkg;

   typedef enum logic [1:0] {
      HOLD,
      DARK,
      PLAY,
      WIN
   } tow_state_t;

   localparam int         CNT_W     = 24;
   localparam logic [7:0] LFSR_SEED = 8'h01;
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/tow_ctrl_lfsr8.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1), free-running, seeded on reset.
module lfsr8
   import tow_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   output logic [7:0] q
);

   logic [7:0] r_q;
   logic       w_fb;

   assign w_fb = ^(r_q & LFSR_TAPS);

   // Step every cycle; a maximal-length sequence never reaches zero from the seed.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_q <= LFSR_SEED;
      end else begin
         r_q <= {r_q[6:0], w_fb};
      end
   end

   assign q = r_q;

endmodule

// File: rtl/tow_ctrl.sv
// Tug-of-war round controller: sequences HOLD/DARK/PLAY rounds, moves the
// rope one step per decided round and latches a winner at either end.
module tow_ctrl
   import tow_pkg::*;
#(
   parameter int LEDS        = 9,
   parameter int DARK_MIN    = 16,
   parameter int DARK_SHIFT  = 0,
   parameter int PLAY_CYCLES = 32,
   parameter int HOLD_CYCLES = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push,
   input  logic            tie,
   input  logic            right,
   output logic            clear,
   output logic [LEDS-1:0] leds,
   output logic            win_l,
   output logic            win_r
);

   localparam int              POS_W       = $clog2(LEDS);
   localparam logic [POS_W-1:0] POS_ONE    = POS_W'(1);
   localparam logic [POS_W-1:0] POS_CENTRE = POS_W'(LEDS / 2);
   localparam logic [POS_W-1:0] POS_LAST   = POS_W'(LEDS - 1);
   localparam logic [LEDS-1:0]  LEDS_CENTRE =
      {{(LEDS / 2){1'b0}}, 1'b1, {(LEDS / 2){1'b0}}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_HOLD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_PLAY = CNT_W'(PLAY_CYCLES - 1);

   tow_state_t       r_state;
   tow_state_t       w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [POS_W-1:0] r_pos;
   logic [POS_W-1:0] w_pos_nxt;
   logic             r_clear;
   logic             w_clear_nxt;
   logic [LEDS-1:0]  r_leds;
   logic [LEDS-1:0]  w_leds_nxt;
   logic             r_win_l;
   logic             w_win_l_nxt;
   logic             r_win_r;
   logic             w_win_r_nxt;
   logic             w_round_end;
   logic [7:0]       w_lfsr;
   logic [CNT_W-1:0] w_dark_load;

   lfsr8 u_lfsr (
      .clk (clk),
      .rst (rst),
      .q   (w_lfsr)
   );

   assign w_dark_load = CNT_W'(DARK_MIN) + (CNT_W'(w_lfsr) << DARK_SHIFT) - CNT_ONE;

   // Next-state, counter, rope position and the output values they imply.
   // Outputs are decoded from the next state so the registered copies line
   // up with the state register on the same edge.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_pos_nxt   = r_pos;
      w_win_l_nxt = r_win_l;
      w_win_r_nxt = r_win_r;
      w_round_end = 1'b0;

      case (r_state)
         HOLD: begin
            if (r_cnt == '0) begin
               w_state_nxt = DARK;
               w_cnt_nxt   = w_dark_load;
            end else begin
               w_cnt_nxt = r_cnt - CNT_ONE;
            end
         end
         DARK: begin
            if (push) begin
               // False start: the early jumper loses a step.
               if (!tie) begin
                  w_pos_nxt = right ? (r_pos - POS_ONE) : (r_pos + POS_ONE);
               end
               w_round_end = 1'b1;
            end else if (r_cnt == '0) begin
               w_state_nxt = PLAY;
               w_cnt_nxt   = CNT_PLAY;
            end else begin
               w_cnt_nxt = r_cnt - CNT_ONE;
            end
         end
         PLAY: begin
            if (push) begin
               if (!tie) begin
                  w_pos_nxt = right ? (r_pos + POS_ONE) : (r_pos - POS_ONE);
               end
               w_round_end = 1'b1;
            end else if (r_cnt == '0) begin
               w_state_nxt = HOLD;
               w_cnt_nxt   = CNT_HOLD;
            end else begin
               w_cnt_nxt = r_cnt - CNT_ONE;
            end
         end
         WIN: begin
            w_state_nxt = WIN;
         end
         default: begin
            w_state_nxt = HOLD;
            w_cnt_nxt   = CNT_HOLD;
         end
      endcase

      if (w_round_end) begin
         if (w_pos_nxt == '0) begin
            w_state_nxt = WIN;
            w_win_l_nxt = 1'b1;
         end else if (w_pos_nxt == POS_LAST) begin
            w_state_nxt = WIN;
            w_win_r_nxt = 1'b1;
         end else begin
            w_state_nxt = HOLD;
            w_cnt_nxt   = CNT_HOLD;
         end
      end

      w_clear_nxt = (w_state_nxt == HOLD) || (w_state_nxt == WIN);

      w_leds_nxt = '0;
      if (w_state_nxt != DARK) begin
         for (int unsigned i = 0; i < LEDS; i++) begin
            w_leds_nxt[i] = (w_pos_nxt == POS_W'(i));
         end
      end
   end

   // State, counter, position and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= HOLD;
         r_cnt   <= CNT_HOLD;
         r_pos   <= POS_CENTRE;
         r_clear <= 1'b1;
         r_leds  <= LEDS_CENTRE;
         r_win_l <= 1'b0;
         r_win_r <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_pos   <= w_pos_nxt;
         r_clear <= w_clear_nxt;
         r_leds  <= w_leds_nxt;
         r_win_l <= w_win_l_nxt;
         r_win_r <= w_win_r_nxt;
      end
   end

   assign clear = r_clear;
   assign leds  = r_leds;
   assign win_l = r_win_l;
   assign win_r = r_win_r;

endmodule

// File: tb/tb_tow_ctrl.sv
// Self-checking bench for tow_ctrl: fixed vector table, directed corner
// sequences and randomized play against a round-level reference model.
module tb_tow_ctrl;

   localparam int LEDS        = 9;
   localparam int DARK_MIN    = 16;
   localparam int DARK_SHIFT  = 0;
   localparam int PLAY_CYCLES = 32;
   localparam int HOLD_CYCLES = 4;

   localparam int PH_HOLD = 0;
   localparam int PH_DARK = 1;
   localparam int PH_PLAY = 2;
   localparam int PH_WIN  = 3;

   localparam logic [LEDS-1:0] CENTRE = 9'b000010000;

   logic            clk   = 1'b0;
   logic            rst   = 1'b0;
   logic            push  = 1'b0;
   logic            tie   = 1'b0;
   logic            right = 1'b0;
   logic            clear;
   logic [LEDS-1:0] leds;
   logic            win_l;
   logic            win_r;

   int total = 0;
   int bad   = 0;

   // Reference model: phase plus cycles remaining in that phase.
   int         m_phase;
   int         m_left;
   int         m_pos;
   logic       m_wl;
   logic       m_wr;
   logic [7:0] m_lfsr;

   tow_ctrl #(
      .LEDS        (LEDS),
      .DARK_MIN    (DARK_MIN),
      .DARK_SHIFT  (DARK_SHIFT),
      .PLAY_CYCLES (PLAY_CYCLES),
      .HOLD_CYCLES (HOLD_CYCLES)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .tie   (tie),
      .right (right),
      .clear (clear),
      .leds  (leds),
      .win_l (win_l),
      .win_r (win_r)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] poly_step(input logic [7:0] q);
      return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
   endfunction

   task automatic end_round();
      if (m_pos == 0) begin
         m_phase = PH_WIN;
         m_wl    = 1'b1;
      end else if (m_pos == LEDS - 1) begin
         m_phase = PH_WIN;
         m_wr    = 1'b1;
      end else begin
         m_phase = PH_HOLD;
         m_left  = HOLD_CYCLES;
      end
   endtask

   task automatic model_edge(input logic r, input logic p, input logic t, input logic rt);
      int dark_len;
      if (!r) begin
         m_phase = PH_HOLD;
         m_left  = HOLD_CYCLES;
         m_pos   = LEDS / 2;
         m_wl    = 1'b0;
         m_wr    = 1'b0;
         m_lfsr  = 8'h01;
         return;
      end
      dark_len = DARK_MIN + (int'(m_lfsr) << DARK_SHIFT);
      case (m_phase)
         PH_HOLD: begin
            if (m_left == 1) begin
               m_phase = PH_DARK;
               m_left  = dark_len;
            end else m_left--;
         end
         PH_DARK: begin
            if (p) begin
               if (!t) m_pos += rt ? -1 : 1;
               end_round();
            end else if (m_left == 1) begin
               m_phase = PH_PLAY;
               m_left  = PLAY_CYCLES;
            end else m_left--;
         end
         PH_PLAY: begin
            if (p) begin
               if (!t) m_pos += rt ? 1 : -1;
               end_round();
            end else if (m_left == 1) begin
               m_phase = PH_HOLD;
               m_left  = HOLD_CYCLES;
            end else m_left--;
         end
         default: ;
      endcase
      m_lfsr = poly_step(m_lfsr);
   endtask

   task automatic chk(input string nm, input logic [LEDS+2:0] got, input logic [LEDS+2:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got clear/leds/wl/wr=%b, required %b", nm, got, exp);
      end
   endtask

   task automatic check_model(input string nm);
      logic [LEDS-1:0] e_leds;
      logic            e_clear;
      e_leds = '0;
      if (m_phase != PH_DARK) e_leds[m_pos] = 1'b1;
      e_clear = (m_phase == PH_HOLD) || (m_phase == PH_WIN);
      chk({nm, "_model"}, {clear, leds, win_l, win_r}, {e_clear, e_leds, m_wl, m_wr});
   endtask

   task automatic tick(input logic r, input logic p, input logic t, input logic rt, input string nm);
      rst   = r;
      push  = p;
      tie   = t;
      right = rt;
      @(posedge clk);
      model_edge(r, p, t, rt);
      #1;
      check_model(nm);
   endtask

   task automatic wait_phase(input int ph, input bit last, input string nm);
      int n;
      n = 0;
      while (!(m_phase == ph && (!last || m_left == 1)) && n < 600) begin
         tick(1'b1, 1'b0, 1'b0, 1'b0, nm);
         n++;
      end
      if (n >= 600) begin
         total++;
         bad++;
         $display("FAIL %s: timeout waiting for phase %0d (model phase %0d)", nm, ph, m_phase);
      end
   endtask

   typedef struct {
      logic            r;
      logic            p;
      logic            t;
      logic            rt;
      int              reps;
      logic            e_clear;
      logic [LEDS-1:0] e_leds;
      logic            e_wl;
      logic            e_wr;
   } vec_t;

   vec_t tbl[6];

   initial begin
      // From reset: 4 HOLD, dark = 16 + 8'h08 (LFSR after three steps), 32 PLAY, 4 HOLD, DARK.
      tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1,  1'b1, CENTRE, 1'b0, 1'b0};
      tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 3,  1'b1, CENTRE, 1'b0, 1'b0};
      tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 24, 1'b0, '0,     1'b0, 1'b0};
      tbl[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 32, 1'b0, CENTRE, 1'b0, 1'b0};
      tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 4,  1'b1, CENTRE, 1'b0, 1'b0};
      tbl[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1,  1'b0, '0,     1'b0, 1'b0};

      for (int v = 0; v < 6; v++) begin
         for (int k = 0; k < tbl[v].reps; k++) begin
            tick(tbl[v].r, tbl[v].p, tbl[v].t, tbl[v].rt, $sformatf("tbl%0d", v));
            chk($sformatf("tbl%0d_rep%0d", v, k), {clear, leds, win_l, win_r},
                {tbl[v].e_clear, tbl[v].e_leds, tbl[v].e_wl, tbl[v].e_wr});
         end
      end

      // Right hit in PLAY, then HOLD for exactly 4 cycles.
      tick(1'b0, 1'b0, 1'b0, 1'b0, "s2_rst");
      wait_phase(PH_PLAY, 1'b0, "s2_wait");
      tick(1'b1, 1'b1, 1'b0, 1'b1, "s2_right");
      chk("s2_right_pos5", {clear, leds, win_l, win_r}, {1'b1, 9'b000100000, 1'b0, 1'b0});
      for (int k = 0; k < 3; k++) begin
         tick(1'b1, 1'b0, 1'b0, 1'b0, "s2_hold");
         chk("s2_hold", {clear, leds, win_l, win_r}, {1'b1, 9'b000100000, 1'b0, 1'b0});
      end
      tick(1'b1, 1'b0, 1'b0, 1'b0, "s2_dark");
      chk("s2_dark_after_hold", {clear, leds, win_l, win_r}, {1'b0, 9'b000000000, 1'b0, 1'b0});

      // Left hit in PLAY from centre.
      tick(1'b0, 1'b0, 1'b0, 1'b0, "s2b_rst");
      wait_phase(PH_PLAY, 1'b0, "s2b_wait");
      tick(1'b1, 1'b1, 1'b0, 1'b0, "s2b_left");
      chk("s2b_left_pos3", {clear, leds, win_l, win_r}, {1'b1, 9'b000001000, 1'b0, 1'b0});

      // False start by right player in DARK.
      tick(1'b0, 1'b0, 1'b0, 1'b0, "s3_rst");
      wait_phase(PH_DARK, 1'b0, "s3_wait");
      tick(1'b1, 1'b1, 1'b0, 1'b1, "s3_false");
      chk("s3_false_start", {clear, leds, win_l, win_r}, {1'b1, 9'b000001000, 1'b0, 1'b0});

      // Ties in DARK and PLAY never move the rope.
      tick(1'b0, 1'b0, 1'b0, 1'b0, "s3t_rst");
      wait_phase(PH_DARK, 1'b0, "s3t_wait_dark");
      tick(1'b1, 1'b1, 1'b1, 1'b1, "s3t_dark_tie");
      chk("s3_dark_tie", {clear, leds, win_l, win_r}, {1'b1, CENTRE, 1'b0, 1'b0});
      wait_phase(PH_PLAY, 1'b0, "s3t_wait_play");
      tick(1'b1, 1'b1, 1'b1, 1'b0, "s3t_play_tie");
      chk("s3_play_tie", {clear, leds, win_l, win_r}, {1'b1, CENTRE, 1'b0, 1'b0});

      // Four right hits reach the right end; WIN then ignores everything but reset.
      tick(1'b0, 1'b0, 1'b0, 1'b0, "s4_rst");
      for (int k = 0; k < 4; k++) begin
         wait_phase(PH_PLAY, 1'b0, "s4_wait");
         tick(1'b1, 1'b1, 1'b0, 1'b1, "s4_hit");
      end
      chk("s4_win_r", {clear, leds, win_l, win_r}, {1'b1, 9'b100000000, 1'b0, 1'b1});
      for (int k = 0; k < 120; k++) begin
         tick(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "s4_sticky");
      end
      chk("s4_win_sticky", {clear, leds, win_l, win_r}, {1'b1, 9'b100000000, 1'b0, 1'b1});

      // Press on the last DARK cycle is a false start; press on the last PLAY cycle is a hit.
      tick(1'b0, 1'b0, 1'b0, 1'b0, "s5_rst");
      wait_phase(PH_DARK, 1'b1, "s5_wait_dark_end");
      tick(1'b1, 1'b1, 1'b0, 1'b0, "s5_dark_edge");
      chk("s5_dark_end_false_start", {clear, leds, win_l, win_r}, {1'b1, 9'b000100000, 1'b0, 1'b0});
      wait_phase(PH_PLAY, 1'b1, "s5_wait_play_end");
      tick(1'b1, 1'b1, 1'b0, 1'b1, "s5_play_edge");
      chk("s5_play_end_hit", {clear, leds, win_l, win_r}, {1'b1, 9'b001000000, 1'b0, 1'b0});

      // Mid-PLAY reset at pos 6 returns to centre in HOLD.
      wait_phase(PH_PLAY, 1'b0, "s6_wait");
      tick(1'b0, 1'b0, 1'b0, 1'b0, "s6_rst");
      chk("s6_reset_midplay", {clear, leds, win_l, win_r}, {1'b1, CENTRE, 1'b0, 1'b0});
      tick(1'b1, 1'b0, 1'b0, 1'b0, "s6_hold");
      chk("s6_hold_after_reset", {clear, leds, win_l, win_r}, {1'b1, CENTRE, 1'b0, 1'b0});

      // Randomized play with occasional resets.
      for (int k = 0; k < 4000; k++) begin
         tick(1'($urandom_range(0, 199) != 0), 1'($urandom_range(0, 5) == 0),
              1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
